vx_mem_rsp_tag_demux: RTL and testbench
=======================================

Name: vx_mem_rsp_tag_demux

Overview:
- Response-side counterpart of the L2-input request arbiter. That arbiter prepends a source index into the low bits of each memory request tag.
- This block accepts memory responses returning from L2 and decodes the source index from the tag LSBs. It strips the index and steers the response to the owning L1 output: icache, dcache, tcache, rcache or ocache.
- It sits between the L2 core-response bus and the L1 cache memory-response ports.
- Each output has a small elastic buffer, so one stalled L1 does not block responses to the others beyond its buffer depth.

Parameters:
- NUM_OUTPUTS, 5: number of L1 outputs; matches NUM_L1_OUTPUTS in VX_cache_types.
- DATA_WIDTH, 512: response data bits (L2_WORD_SIZE*8).
- TAG_IN_WIDTH, 12: incoming response tag width (L2_TAG_WIDTH).
- SEL_BITS, `CLOG2(NUM_OUTPUTS) (min 1): source-index field width, located in tag[SEL_BITS-1:0].
- TAG_OUT_WIDTH, TAG_IN_WIDTH-SEL_BITS: tag width delivered to each L1.
- BUF_DEPTH, 2: entries per output buffer; power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_rsp_valid  in  1  response valid.
- mem_rsp_data  in  DATA_WIDTH  response data.
- mem_rsp_tag  in  TAG_IN_WIDTH  response tag; LSBs hold the source index.
- mem_rsp_ready  out  1  response accepted.
- out_rsp_valid  out  NUM_OUTPUTS  per-output valid.
- out_rsp_data  out  NUM_OUTPUTS*DATA_WIDTH  per-output data, packed with output i at slice i.
- out_rsp_tag  out  NUM_OUTPUTS*TAG_OUT_WIDTH  per-output tag = mem_rsp_tag[TAG_IN_WIDTH-1:SEL_BITS].
- out_rsp_ready  in  NUM_OUTPUTS  per-output ready.
- drop_count  out  8  saturating count of responses with an invalid source index.
- drop_sticky  out  1  set on the first drop.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All buffers empty; out_rsp_valid=0.
  - drop_count=0, drop_sticky=0.
  - mem_rsp_ready=1 once reset is released.
  - Reset mid-operation discards all buffered entries with no partial output.
- Decode: sel = mem_rsp_tag[SEL_BITS-1:0].
- Handshake, valid/ready: a transfer occurs when valid && ready.
  - Valid must not depend on ready.
  - Payload is held stable while valid && !ready.
- mem_rsp_ready:
  - Equals !full[sel] when sel < NUM_OUTPUTS.
  - Equals 1 when sel ≥ NUM_OUTPUTS (response is accepted and dropped).
  - Depends only on buffer state and the tag, never on out_rsp_ready, so there is no combinational ready path.
- Enqueue: the accepted response is written into buffer[sel] with {data, stripped tag}.
- Latency: 1 cycle; the response appears on out_rsp_valid[sel] the cycle after acceptance.
- Per-output buffer: circular FIFO with rd_ptr, wr_ptr and count of $clog2(BUF_DEPTH)+1 bits.
  - Pointers wrap modulo BUF_DEPTH.
  - full = (count==BUF_DEPTH); empty = (count==0).
  - out_rsp_valid[i] = !empty[i]; head data and tag are driven from registered storage.
  - Dequeue when out_rsp_valid[i] && out_rsp_ready[i].
- Simultaneous enqueue and dequeue on the same output:
  - Non-full buffer: count unchanged, both pointers advance.
  - Full buffer: enqueue is not allowed, since ready was already low.
  - Empty buffer: the new entry is visible the next cycle (no bypass).
- Throughput: with BUF_DEPTH=2 and continuous out_rsp_ready, sustains one response per cycle per output.
- Outputs are independent; a full buffer on output i stalls only responses targeting i.
- Drops (sel ≥ NUM_OUTPUTS):
  - drop_count increments and saturates at 255.
  - drop_sticky sets and stays set until reset.
  - No output buffer changes.
- Ordering: FIFO order is preserved per output; no ordering is implied across outputs.

Decomposition:
- Shared package VX_cache_types gains:
  - L1_RSP_SEL_BITS = `CLOG2(NUM_L1_OUTPUTS).
  - Index constants L1_OUT_ICACHE=0, L1_OUT_DCACHE=1, L1_OUT_TCACHE=2, L1_OUT_RCACHE=3, L1_OUT_OCACHE=4, shared with the request arbiter.
  - A typedef for the response payload struct {data, tag}.
- Sub-module vx_rsp_elastic_buf (one instance per output): parameterised FIFO with asynchronous active-low reset, full/empty flags, and registered outputs.

Test Plan:
- Reset, then a single response with tag=0x0A1 (sel=1, NUM_OUTPUTS=5, SEL_BITS=3, TAG_IN_WIDTH=12) and data=0xDEAD... → next cycle out_rsp_valid=5'b00010, out_rsp_tag[1]=0x014, data matches; all other valids 0.
- out_rsp_ready[2]=0 while 3 responses target sel=2 → first 2 accepted; mem_rsp_ready=0 on the third; raising out_rsp_ready[2] drains them in order, and the third is accepted the cycle after the first dequeue.
- Interleaved sel=0,3,0,3 with all outputs ready → 1 response/cycle, per-output order preserved, no bubbles.
- tag with sel=7 (invalid) repeated 300 times → always accepted, no out_rsp_valid; drop_sticky=1, drop_count=255.
- Buffer[4] holding 2 entries, reset_n pulsed low asynchronously mid-cycle → out_rsp_valid=0 immediately; drop_count=0; mem_rsp_ready=1 after release.
- Full buffer[1] with simultaneous dequeue and a new sel=1 request → ready=0 that cycle; accepted next cycle; count sequence 2→1→2.

Source files
------------

// File: rtl/vx_mem_rsp_tag_demux_pkg.sv
// Shared L1/L2 response-path constants and types: output indices, the source-index
// field width and the response payload carried to each L1.
package vx_mem_rsp_tag_demux_pkg;

    localparam int NUM_L1_OUTPUTS  = 5;
    localparam int L1_RSP_SEL_BITS = (NUM_L1_OUTPUTS > 1) ? $clog2(NUM_L1_OUTPUTS) : 1;

    // Source indices shared with the L2-input request arbiter
    localparam int L1_OUT_ICACHE = 0;
    localparam int L1_OUT_DCACHE = 1;
    localparam int L1_OUT_TCACHE = 2;
    localparam int L1_OUT_RCACHE = 3;
    localparam int L1_OUT_OCACHE = 4;

    localparam int L2_RSP_DATA_WIDTH = 512;
    localparam int L2_TAG_WIDTH      = 12;
    localparam int L1_RSP_TAG_WIDTH  = L2_TAG_WIDTH - L1_RSP_SEL_BITS;

    typedef struct packed {
        logic [L2_RSP_DATA_WIDTH-1:0] data;
        logic [L1_RSP_TAG_WIDTH-1:0]  tag;
    } l1_rsp_payload_t;

endpackage

// File: rtl/vx_mem_rsp_tag_demux_buf.sv
// Per-output elastic buffer: circular FIFO with registered head, no write-through bypass.
// i_push must only be asserted when o_full is low.
module vx_rsp_elastic_buf
    import vx_mem_rsp_tag_demux_pkg::*;
#(
    parameter int DATA_WIDTH = L2_RSP_DATA_WIDTH,
    parameter int TAG_WIDTH  = L1_RSP_TAG_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic [TAG_WIDTH-1:0]  i_push_tag,
    output logic                  o_full,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [TAG_WIDTH-1:0]  o_tag,
    input  logic                  i_ready
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_data_mem [BUF_DEPTH];
    logic [TAG_WIDTH-1:0]  r_tag_mem  [BUF_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(BUF_DEPTH));
    assign o_valid = !w_empty;
    assign w_push  = i_push && !o_full;
    assign w_pop   = !w_empty && i_ready;

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= i_push_data;
            r_tag_mem[r_wr_ptr]  <= i_push_tag;
        end
    end

    assign o_data = r_data_mem[r_rd_ptr];
    assign o_tag  = r_tag_mem[r_rd_ptr];

endmodule

// File: rtl/vx_mem_rsp_tag_demux.sv
// Steers L2 memory responses to the owning L1 using the source index held in the tag
// LSBs; unknown indices are accepted and counted as drops.
module vx_mem_rsp_tag_demux
    import vx_mem_rsp_tag_demux_pkg::*;
#(
    parameter int NUM_OUTPUTS   = NUM_L1_OUTPUTS,
    parameter int DATA_WIDTH    = L2_RSP_DATA_WIDTH,
    parameter int TAG_IN_WIDTH  = L2_TAG_WIDTH,
    parameter int SEL_BITS      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH - SEL_BITS,
    parameter int BUF_DEPTH     = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
    input  logic [TAG_IN_WIDTH-1:0]            mem_rsp_tag,
    output logic                               mem_rsp_ready,
    output logic [NUM_OUTPUTS-1:0]             out_rsp_valid,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]  out_rsp_data,
    output logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0] out_rsp_tag,
    input  logic [NUM_OUTPUTS-1:0]             out_rsp_ready,
    output logic [7:0]                         drop_count,
    output logic                               drop_sticky
);

    logic [SEL_BITS-1:0]      w_sel;
    logic [TAG_OUT_WIDTH-1:0] w_tag_strip;
    logic [NUM_OUTPUTS-1:0]   w_hit;
    logic [NUM_OUTPUTS-1:0]   w_full;
    logic                     w_sel_ok;
    logic                     w_drop;
    logic [7:0]               r_drop_count;
    logic                     r_drop_sticky;

    assign w_sel       = mem_rsp_tag[SEL_BITS-1:0];
    assign w_tag_strip = mem_rsp_tag[TAG_IN_WIDTH-1:SEL_BITS];

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
        assign w_hit[i] = (w_sel == SEL_BITS'(i));

        vx_rsp_elastic_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_OUT_WIDTH),
            .BUF_DEPTH  (BUF_DEPTH)
        ) u_buf (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_push      (mem_rsp_valid && w_hit[i]),
            .i_push_data (mem_rsp_data),
            .i_push_tag  (w_tag_strip),
            .o_full      (w_full[i]),
            .o_valid     (out_rsp_valid[i]),
            .o_data      (out_rsp_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_tag       (out_rsp_tag[i*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]),
            .i_ready     (out_rsp_ready[i])
        );
    end

    // Ready looks only at buffer occupancy and the tag, never at out_rsp_ready
    assign w_sel_ok      = |w_hit;
    assign mem_rsp_ready = w_sel_ok ? !(|(w_hit & w_full)) : 1'b1;
    assign w_drop        = mem_rsp_valid && !w_sel_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count  <= '0;
            r_drop_sticky <= 1'b0;
        end else if (w_drop) begin
            r_drop_sticky <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign drop_count  = r_drop_count;
    assign drop_sticky = r_drop_sticky;

endmodule

// File: tb/tb_vx_mem_rsp_tag_demux.sv
// Bench for vx_mem_rsp_tag_demux: directed vector table, drop/reset sequences and a
// randomized phase, all checked against a queue-based model of the response steering.
module tb_vx_mem_rsp_tag_demux;
    import vx_mem_rsp_tag_demux_pkg::*;

    localparam int NO  = 5;
    localparam int DW  = 512;
    localparam int TW  = 12;
    localparam int SB  = 3;
    localparam int TOW = TW - SB;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;
    logic [TW-1:0]     mem_rsp_tag;
    logic              mem_rsp_ready;
    logic [NO-1:0]     out_rsp_valid;
    logic [NO*DW-1:0]  out_rsp_data;
    logic [NO*TOW-1:0] out_rsp_tag;
    logic [NO-1:0]     out_rsp_ready;
    logic [7:0]        drop_count;
    logic              drop_sticky;

    always #5 clk = ~clk;

    vx_mem_rsp_tag_demux dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_tag   (mem_rsp_tag),
        .mem_rsp_ready (mem_rsp_ready),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_data  (out_rsp_data),
        .out_rsp_tag   (out_rsp_tag),
        .out_rsp_ready (out_rsp_ready),
        .drop_count    (drop_count),
        .drop_sticky   (drop_sticky)
    );

    // Reference model: one queue per L1 output plus a count of dropped responses
    l1_rsp_payload_t mq [NO][$];
    int n_drops;
    int checks;
    int errors;

    typedef struct {
        logic          vld;
        logic [TW-1:0] tag;
        logic [NO-1:0] ordy;
        logic          exp_rdy;
        logic [NO-1:0] exp_ov;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(logic v, logic [TW-1:0] t, logic [NO-1:0] r,
                                    logic er, logic [NO-1:0] eov);
        vec_t e;
        e.vld = v; e.tag = t; e.ordy = r; e.exp_rdy = er; e.exp_ov = eov;
        tbl.push_back(e);
    endfunction

    function automatic logic [DW-1:0] data_for_tag(logic [TW-1:0] t);
        if (t == 12'h0A1) return {16{32'hDEADBEEF}};
        return {16{(32'(t) * 32'h01010101) ^ 32'hA5A5A5A5}};
    endfunction

    function automatic logic model_ready(logic [TW-1:0] t);
        int s;
        s = int'(t[SB-1:0]);
        if (s >= NO) return 1'b1;
        return (mq[s].size() < 2);
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [NO-1:0] ev;
        for (int i = 0; i < NO; i++) ev[i] = (mq[i].size() > 0);
        chk("mem_rsp_ready", DW'(mem_rsp_ready), DW'(model_ready(mem_rsp_tag)));
        chk("out_rsp_valid", DW'(out_rsp_valid), DW'(ev));
        for (int i = 0; i < NO; i++) begin
            if (ev[i]) begin
                chk($sformatf("out_rsp_data[%0d]", i), out_rsp_data[i*DW +: DW], mq[i][0].data);
                chk($sformatf("out_rsp_tag[%0d]", i), DW'(out_rsp_tag[i*TOW +: TOW]), DW'(mq[i][0].tag));
            end
        end
        chk("drop_count", DW'(drop_count), DW'((n_drops > 255) ? 255 : n_drops));
        chk("drop_sticky", DW'(drop_sticky), DW'(n_drops > 0));
    endtask

    // Apply one clock edge to the model using the inputs held across that edge
    task automatic update_model();
        logic acc;
        int s;
        l1_rsp_payload_t e;
        acc = mem_rsp_valid && model_ready(mem_rsp_tag);
        for (int i = 0; i < NO; i++) begin
            if (out_rsp_ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        end
        if (acc) begin
            s = int'(mem_rsp_tag[SB-1:0]);
            if (s < NO) begin
                e.data = mem_rsp_data;
                e.tag  = mem_rsp_tag[TW-1:SB];
                mq[s].push_back(e);
            end else begin
                n_drops++;
            end
        end
    endtask

    task automatic edge_step();
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drive(logic v, logic [TW-1:0] t, logic [NO-1:0] r);
        mem_rsp_valid = v;
        mem_rsp_tag   = t;
        mem_rsp_data  = data_for_tag(t);
        out_rsp_ready = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic last_acc;
        checks = 0; errors = 0; n_drops = 0;
        reset_n = 1'b0;
        drive(1'b0, '0, '1);

        //        vld  tag      ordy      rdy  out_valid
        add_vec(1'b1, 12'h0A1, 5'b11111, 1'b1, 5'b00000);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00010);
        add_vec(1'b1, 12'h102, 5'b11011, 1'b1, 5'b00000);
        add_vec(1'b1, 12'h112, 5'b11011, 1'b1, 5'b00100);
        add_vec(1'b1, 12'h122, 5'b11011, 1'b0, 5'b00100);
        add_vec(1'b1, 12'h122, 5'b11111, 1'b0, 5'b00100);
        add_vec(1'b1, 12'h122, 5'b11011, 1'b1, 5'b00100);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00100);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00100);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00000);
        add_vec(1'b1, 12'h0B0, 5'b11111, 1'b1, 5'b00000);
        add_vec(1'b1, 12'h0C3, 5'b11111, 1'b1, 5'b00001);
        add_vec(1'b1, 12'h0D0, 5'b11111, 1'b1, 5'b01000);
        add_vec(1'b1, 12'h0E3, 5'b11111, 1'b1, 5'b00001);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b01000);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00000);
        add_vec(1'b1, 12'h201, 5'b11101, 1'b1, 5'b00000);
        add_vec(1'b1, 12'h211, 5'b11101, 1'b1, 5'b00010);
        add_vec(1'b1, 12'h221, 5'b11111, 1'b0, 5'b00010);
        add_vec(1'b1, 12'h221, 5'b11101, 1'b1, 5'b00010);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00010);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00010);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00000);
        add_vec(1'b1, 12'h0A7, 5'b11111, 1'b1, 5'b00000);
        add_vec(1'b0, 12'h000, 5'b11111, 1'b1, 5'b00000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", DW'(out_rsp_valid), DW'(0));
        chk("reset_drop_count", DW'(drop_count), DW'(0));
        chk("reset_drop_sticky", DW'(drop_sticky), DW'(0));
        reset_n = 1'b1;
        #1;
        chk("release_ready", DW'(mem_rsp_ready), DW'(1));
        @(posedge clk);
        #1;

        // Directed vector table
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].vld, tbl[k].tag, tbl[k].ordy);
            #1;
            chk($sformatf("vec%0d_ready", k), DW'(mem_rsp_ready), DW'(tbl[k].exp_rdy));
            chk($sformatf("vec%0d_valid", k), DW'(out_rsp_valid), DW'(tbl[k].exp_ov));
            if (tbl[k].exp_ov == 5'b00010 && k == 1) begin
                chk("vec1_tag_strip", DW'(out_rsp_tag[TOW +: TOW]), DW'(9'h014));
                chk("vec1_data", out_rsp_data[DW +: DW], {16{32'hDEADBEEF}});
            end
            edge_step();
        end

        // Invalid source index repeated until the drop counter saturates
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, {9'($urandom), 3'b111}, 5'($urandom));
            #1;
            chk("drop_ready", DW'(mem_rsp_ready), DW'(1));
            edge_step();
        end
        drive(1'b0, '0, '1);
        #1;
        chk("drop_sat", DW'(drop_count), DW'(255));
        chk("drop_sticky_set", DW'(drop_sticky), DW'(1));
        chk("drop_no_valid", DW'(out_rsp_valid), DW'(0));
        edge_step();

        // Two entries parked in buffer[4], then an asynchronous mid-cycle reset
        drive(1'b1, 12'h304, 5'b00000);
        #1; edge_step();
        drive(1'b1, 12'h314, 5'b00000);
        #1; edge_step();
        drive(1'b0, '0, 5'b00000);
        #1;
        chk("pre_reset_valid", DW'(out_rsp_valid), DW'(5'b10000));
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < NO; i++) mq[i].delete();
        n_drops = 0;
        #1;
        chk("async_reset_valid", DW'(out_rsp_valid), DW'(0));
        chk("async_reset_drops", DW'(drop_count), DW'(0));
        chk("async_reset_sticky", DW'(drop_sticky), DW'(0));
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 12'h304, 5'b11111);
        #1;
        chk("post_reset_ready", DW'(mem_rsp_ready), DW'(1));
        chk("post_reset_valid", DW'(out_rsp_valid), DW'(0));
        edge_step();

        // Randomized traffic; a stalled request keeps its payload until accepted
        last_acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!(mem_rsp_valid && !last_acc)) begin
                mem_rsp_valid = ($urandom_range(0, 3) != 0);
                mem_rsp_tag   = 12'($urandom);
                for (int j = 0; j < 16; j++) mem_rsp_data[j*32 +: 32] = $urandom;
            end
            for (int i = 0; i < NO; i++) out_rsp_ready[i] = ($urandom_range(0, 3) != 0);
            #1;
            last_acc = model_ready(mem_rsp_tag);
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
